// File: rtl/nixie_pkg.sv
// Shared constants for the nixie scan driver: hex segment table and polarity-free
// logical segment levels ({g,f,e,d,c,b,a}, 1 = lit).
package nixie_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ON  = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/nixie_hex_decode.sv
// Combinational 4-to-7 hex decoder driven from the shared segment table.
import nixie_pkg::*;

module nixie_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/nixie_scan_driver.sv
// Multiplexed hex display driver with prescaled digit scan and frame-aligned double buffer.
// Optional build macro NIXIE_LZ_BLANK_EN enables leading-zero blanking.
import nixie_pkg::*;

module nixie_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
  localparam logic          POL      = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]         pcnt, pcnt_next;
  logic [IW-1:0]         idx, idx_next;
  logic                  tick, wrap;
  logic [4*DIGITS-1:0]   pend_data, pend_data_next, disp_data, disp_data_next;
  logic [DIGITS-1:0]     pend_dp, pend_dp_next, disp_dp, disp_dp_next;
  logic                  pend_v, pend_v_next;
  logic [DIGITS-1:0]     an_next;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  lz_blank;

  always_comb begin
    tick      = en && (pcnt == PCNT_MAX);
    wrap      = tick && (idx == IDX_MAX);
    pcnt_next = pcnt;
    idx_next  = idx;
    if (en) pcnt_next = tick ? '0 : pcnt + 1'b1;
    if (tick) idx_next = (idx == IDX_MAX) ? '0 : idx + 1'b1;
  end

  // A load landing on the wrap edge goes straight to the display, bypassing pending.
  always_comb begin
    pend_data_next = pend_data;
    pend_dp_next   = pend_dp;
    pend_v_next    = pend_v;
    disp_data_next = disp_data;
    disp_dp_next   = disp_dp;
    if (wrap && load) begin
      disp_data_next = data;
      disp_dp_next   = dp;
      pend_v_next    = 1'b0;
    end else if (wrap && pend_v) begin
      disp_data_next = pend_data;
      disp_dp_next   = pend_dp;
      pend_v_next    = 1'b0;
    end else if (load) begin
      pend_data_next = data;
      pend_dp_next   = dp;
      pend_v_next    = 1'b1;
    end
  end

  always_comb begin
    an_next           = '0;
    an_next[idx_next] = 1'b1;
    nibble            = disp_data_next[{idx_next, 2'b00} +: 4];
  end

  nixie_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef NIXIE_LZ_BLANK_EN
  // Blank a non-zero position only when it and every more significant nibble are zero.
  always_comb begin
    lz_blank = 1'b0;
    if (idx_next != '0) begin
      lz_blank = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
        if ((IW'(j) >= idx_next) && (disp_data_next[4*j +: 4] != 4'h0)) lz_blank = 1'b0;
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_v     <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      frame_done <= 1'b0;
      an         <= {DIGITS{POL}};
      seg        <= SEG_OFF ^ {7{POL}};
      seg_dp     <= POL;
    end else begin
      pcnt       <= pcnt_next;
      idx        <= idx_next;
      pend_data  <= pend_data_next;
      pend_dp    <= pend_dp_next;
      pend_v     <= pend_v_next;
      disp_data  <= disp_data_next;
      disp_dp    <= disp_dp_next;
      frame_done <= wrap;
      if (en) begin
        an     <= an_next ^ {DIGITS{POL}};
        seg    <= (lz_blank ? SEG_OFF : dec_seg) ^ {7{POL}};
        seg_dp <= disp_dp_next[idx_next] ^ POL;
      end else begin
        an     <= {DIGITS{POL}};
        seg    <= SEG_OFF ^ {7{POL}};
        seg_dp <= POL;
      end
    end
  end

endmodule
